pipelined_rc_adder: RTL and testbench



---
 rtl/pipelined_rc_adder_if.sv | 30 +++
 rtl/pipelined_rc_adder.sv | 123 ++++++++++++
 tb/tb_pipelined_rc_adder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_rc_adder_if.sv
// Handshake and data bundle for pipelined_rc_adder.
//   in_valid/in_ready  : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready: result handshake (sum, cout, ovf)
// master: the block that issues operands and consumes results.
// slave : the adder itself.
interface pipelined_rc_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder/subtractor.
// Operands are cut into CHUNK-bit slices; stage k adds slice k and hands its
// carry to stage k+1 through a register, so latency is STAGES = WIDTH/CHUNK
// cycles at one result per cycle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, flushes every in-flight beat
//   bus    : pipelined_rc_adder_if.slave
//            in_valid/in_ready, a, b, cin, sub  -> operand beat
//            out_valid/out_ready, sum, cout, ovf -> result beat
//            sub=0: a+b+cin, sub=1: a-b-cin (cout=1 means no borrow)
module pipelined_rc_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_rc_adder_if.slave    bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("pipelined_rc_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // Each stage register keeps the whole operand words (upper slices are the
    // skew path, lower sum slices the de-skew path); unused bits trim away.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];

    logic [CHUNK:0]    sl    [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [STAGES-1:0] c_nxt;

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              advance;

    function automatic logic [CHUNK:0] add_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Subtraction is a + ~b + 1; a borrow-in removes that +1.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.cin ^ bus.sub;

    // The whole pipe moves as one unit: it only stalls when a finished
    // result is waiting and nobody takes it.
    assign advance      = !v_q[LAST] || bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin
        a_in[0] = bus.a;
        b_in[0] = b_eff;
        s_in[0] = '0;
        c_in[0] = cin_eff;
        v_in[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    always_comb begin
        c_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl[k]    = add_slice(a_in[k][k*CHUNK +: CHUNK],
                                 b_in[k][k*CHUNK +: CHUNK],
                                 c_in[k]);
            s_nxt[k] = s_in[k];
            s_nxt[k][k*CHUNK +: CHUNK] = sl[k][CHUNK-1:0];
            c_nxt[k] = sl[k][CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            v_q <= v_in;
            c_q <= c_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nxt[k];
            end
        end
    end

    // The last stage registers are the output registers. Overflow is decoded
    // from the sign bits held there, so it is as stable as sum during a stall
    // and reads 0 out of reset (all sign bits 0).
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                           (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_rc_adder.sv
module tb_pipelined_rc_adder;
    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc_cyc;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4;
    exp_t e8;
    logic [9:0] held8;
    bit         stalled8 = 0;

    pipelined_rc_adder_if #(.WIDTH(4)) if4 ();
    pipelined_rc_adder_if #(.WIDTH(8)) if8 ();

    pipelined_rc_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    pipelined_rc_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Issue one beat to the 8-bit DUT. While it is refused, the operands are
    // scrambled so a DUT that samples outside the accept edge is exposed.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic s, input logic [7:0] es, input logic ec,
                         input logic eo, input bit lat);
        exp_t e;
        bit acc = 0;
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.a = a; if8.b = b; if8.cin = ci; if8.sub = s;
        for (int t = 0; t < 100 && !acc; t++) begin
            #1;
            if (if8.in_ready) begin
                @(posedge clk);
                acc = 1;
            end else begin
                if8.a = ~a; if8.b = ~b; if8.cin = ~ci; if8.sub = ~s;
                @(negedge clk);
                if8.a = a; if8.b = b; if8.cin = ci; if8.sub = s;
            end
        end
        #1;
        if8.in_valid = 1'b0;
        if (!acc) begin
            chk("dut8 accept timeout", 0, 1);
        end else begin
            e.sum = es; e.cout = ec; e.ovf = eo; e.acc_cyc = cyc; e.lat = lat;
            q8.push_back(e);
        end
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] es,
                         input logic ec, input logic eo);
        exp_t e;
        bit acc = 0;
        @(negedge clk);
        if4.in_valid = 1'b1;
        if4.a = a; if4.b = b; if4.cin = 1'b0; if4.sub = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            #1;
            if (if4.in_ready) begin
                @(posedge clk);
                acc = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        if4.in_valid = 1'b0;
        if (!acc) begin
            chk("dut4 accept timeout", 0, 1);
        end else begin
            e.sum = {4'h0, es}; e.cout = ec; e.ovf = eo; e.acc_cyc = cyc; e.lat = 1;
            q4.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && if4.out_valid) begin
            if (q4.size() == 0) begin
                chk("dut4 unexpected out_valid", 1, 0);
            end else begin
                e4 = q4.pop_front();
                chk("dut4 result {cout,ovf,sum}", {if4.cout, if4.ovf, if4.sum},
                    {e4.cout, e4.ovf, e4.sum[3:0]});
                if (e4.lat) chk("dut4 latency", cyc - e4.acc_cyc, 3);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            stalled8 = 0;
        end else if (if8.out_valid && if8.out_ready) begin
            stalled8 = 0;
            if (q8.size() == 0) begin
                chk("dut8 unexpected out_valid", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("dut8 result {cout,ovf,sum}", {if8.cout, if8.ovf, if8.sum},
                    {e8.cout, e8.ovf, e8.sum});
                if (e8.lat) chk("dut8 latency", cyc - e8.acc_cyc, 1);
            end
        end else if (if8.out_valid) begin
            chk("dut8 in_ready during stall", if8.in_ready, 0);
            if (stalled8) chk("dut8 held output", {if8.cout, if8.ovf, if8.sum}, held8);
            held8 = {if8.cout, if8.ovf, if8.sum};
            stalled8 = 1;
        end else begin
            stalled8 = 0;
        end
    end

    task automatic drain();
        for (int t = 0; t < 50 && (q4.size() != 0 || q8.size() != 0); t++) @(negedge clk);
        chk("dut4 all results delivered", q4.size(), 0);
        chk("dut8 all results delivered", q8.size(), 0);
    endtask

    initial begin
        int sa, sb, s;
        if4.in_valid = 0; if4.a = 0; if4.b = 0; if4.cin = 0; if4.sub = 0; if4.out_ready = 1;
        if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.cin = 0; if8.sub = 0; if8.out_ready = 1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", if8.out_valid, 0);
        chk("reset sum", if8.sum, 0);
        chk("reset cout/ovf", {if8.cout, if8.ovf}, 0);
        chk("reset in_ready", if8.in_ready, 1);
        chk("reset dut4 out_valid", if4.out_valid, 0);
        rst_n = 1;

        // Directed add/sub vectors: a, b, cin, sub -> sum, cout, ovf
        send8(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
        send8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 1);
        send8(8'h3C, 8'h45, 1, 0, 8'h82, 0, 1, 1);
        send8(8'hC0, 8'hC0, 0, 0, 8'h80, 1, 0, 1);
        send8(8'h05, 8'h07, 0, 1, 8'hFE, 0, 0, 1);
        send8(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 1);
        send8(8'h10, 8'h01, 1, 1, 8'h0E, 1, 0, 1);
        send8(8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 1);
        send8(8'h7F, 8'hFF, 0, 1, 8'h80, 0, 1, 1);

        // Exhaustive 4-bit adds, back to back, one slice per stage
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                sa = (a >= 8) ? a - 16 : a;
                sb = (b >= 8) ? b - 16 : b;
                s  = a + b;
                send4(4'(a), 4'(b), 4'(s % 16), s > 15, (sa + sb > 7) || (sa + sb < -8));
            end
        end

        // Bubbles: every other slot empty
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send8(8'(8'h20 + i), 8'h05, 0, 0, 8'(8'h25 + i), 0, 0, 1);
            else @(negedge clk);
        end
        drain();

        // Backpressure: output held off for three cycles mid-stream
        fork
            begin
                for (int i = 1; i <= 6; i++) send8(8'(i), 8'(i), 0, 0, 8'(2 * i), 0, 0, 0);
            end
            begin
                repeat (3) @(negedge clk);
                if8.out_ready = 0;
                repeat (3) @(negedge clk);
                if8.out_ready = 1;
            end
        join
        drain();

        // Reset with two beats in flight
        send8(8'h11, 8'h22, 0, 0, 8'h33, 0, 0, 1);
        send8(8'h44, 8'h11, 0, 0, 8'h55, 0, 0, 1);
        chk("pre-reset out_valid", if8.out_valid, 1);
        rst_n = 0;
        #1;
        chk("async reset out_valid", if8.out_valid, 0);
        chk("async reset in_ready", if8.in_ready, 1);
        chk("async reset sum", if8.sum, 0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        send8(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
